// File: rtl/irq_priority_sched_if.sv
// Request/grant/service bundle between peripherals, the agent and irq_priority_sched.
// master: peripheral and agent side. slave: the scheduler.
interface irq_priority_sched_if #(
    parameter int NCH = 9
);
    logic [NCH-1:0] req;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] pending;
    logic           irq_valid;
    logic [3:0]     irq_id;
    logic           irq_ack;
    logic           eoi;
    logic           busy;
    logic           timeout_err;

    modport master (
        output req, mask, irq_ack, eoi,
        input  irq_valid, irq_id, busy, pending, timeout_err
    );

    modport slave (
        input  req, mask, irq_ack, eoi,
        output irq_valid, irq_id, busy, pending, timeout_err
    );
endinterface

// File: rtl/irq_priority_sched.sv
// Registered interrupt scheduler: latch, mask, arbitrate, present, service.
// Optional IRQ_ROTATE_PRIO_EN: round-robin priority starting after the last serviced channel.
module irq_priority_sched #(
    parameter int NCH         = 9,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input logic clock,
    input logic reset,
    irq_priority_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [NCH-1:0]   eligible, clr;
    logic [3:0]       id_q, id_d;
    logic [3:0]       winner;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic             ack_take;

`ifdef IRQ_ROTATE_PRIO_EN
    logic [3:0] base_q, base_d;
    int         dist, best_dist;
`endif

    assign eligible = pending_q & ~bus.mask;

    always_comb begin
        winner = '0;
`ifdef IRQ_ROTATE_PRIO_EN
        // Smallest upward distance from the base pointer, with wrap-around.
        best_dist = NCH;
        dist      = 0;
        for (int i = 0; i < NCH; i++) begin
            dist = (i >= int'(base_q)) ? i - int'(base_q) : i + NCH - int'(base_q);
            if (eligible[i] && dist < best_dist) begin
                best_dist = dist;
                winner    = 4'(i);
            end
        end
`else
        for (int i = NCH - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 4'(i);
        end
`endif
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        terr_d   = 1'b0;
        ack_take = 1'b0;
`ifdef IRQ_ROTATE_PRIO_EN
        base_d   = base_q;
`endif
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    id_d    = winner;
                    cnt_d   = '0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // An ack on the final allowed cycle beats the timeout.
                if (bus.irq_ack) begin
                    ack_take = 1'b1;
                    state_d  = SERVICE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    id_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SERVICE: begin
                if (bus.eoi) begin
                    id_d    = '0;
                    state_d = IDLE;
`ifdef IRQ_ROTATE_PRIO_EN
                    base_d  = (id_q == 4'(NCH - 1)) ? 4'd0 : id_q + 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request on the ack cycle re-pends its channel: set beats clear.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            clr[i] = ack_take && (id_q == 4'(i));
        end
        pending_d = (pending_q & ~clr) | bus.req;
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
`ifdef IRQ_ROTATE_PRIO_EN
            base_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
`ifdef IRQ_ROTATE_PRIO_EN
            base_q    <= base_d;
`endif
        end
    end

    assign bus.irq_valid   = (state_q == PRESENT);
    assign bus.busy        = (state_q == SERVICE);
    assign bus.irq_id      = id_q;
    assign bus.pending     = pending_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_irq_priority_sched.sv
// Directed bench for irq_priority_sched (NCH=9, ACK_TIMEOUT=4); honours IRQ_ROTATE_PRIO_EN.
module tb_irq_priority_sched;

    localparam int NCH = 9;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    irq_priority_sched_if #(.NCH(NCH)) bus ();

    irq_priority_sched #(
        .NCH(NCH),
        .ACK_TIMEOUT(4),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept the presented grant, then end service; leaves the scheduler in IDLE.
    task automatic serve();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.eoi     = 1'b1;
        tick();
        bus.eoi     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_id;

        reset       = 1'b1;
        bus.req     = '0;
        bus.mask    = '0;
        bus.irq_ack = 1'b0;
        bus.eoi     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", bus.irq_valid, 0);
        check("rst_id", bus.irq_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_terr", bus.timeout_err, 0);

        // ch1 and ch4 requested: ch1 first, ch4 two cycles after eoi.
        bus.req = 9'h012;
        tick();
        bus.req = '0;
        check("t1_pend_latched", bus.pending, 9'h012);
        check("t1_valid_early", bus.irq_valid, 0);
        tick();
        check("t1_valid", bus.irq_valid, 1);
        check("t1_id", bus.irq_id, 1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("t1_busy", bus.busy, 1);
        check("t1_valid_drop", bus.irq_valid, 0);
        check("t1_pend_clr", bus.pending, 9'h010);
        check("t1_svc_id", bus.irq_id, 1);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check("t1_eoi_busy", bus.busy, 0);
        check("t1_eoi_id", bus.irq_id, 0);
        check("t1_gap_valid", bus.irq_valid, 0);
        tick();
        check("t1_ch4_valid", bus.irq_valid, 1);
        check("t1_ch4_id", bus.irq_id, 4);
        serve();

        // Higher-priority request during PRESENT must not steal the grant.
        bus.req = 9'h008;
        tick();
        bus.req = '0;
        tick();
        check("t2_id3", bus.irq_id, 3);
        bus.req = 9'h001;
        tick();
        bus.req = '0;
        tick();
        check("t2_frozen_valid", bus.irq_valid, 1);
        check("t2_frozen_id", bus.irq_id, 3);
        check("t2_pend", bus.pending, 9'h009);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("t2_svc_id", bus.irq_id, 3);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        check("t2_ch0_valid", bus.irq_valid, 1);
        check("t2_ch0_id", bus.irq_id, 0);
        serve();

        // Masked ch0 keeps its pending bit and wins once unmasked.
        bus.mask = 9'h001;
        bus.req  = 9'h003;
        tick();
        bus.req = '0;
        tick();
        check("t3_id1", bus.irq_id, 1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.mask    = '0;
        check("t3_pend0_kept", bus.pending, 9'h001);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
        check("t3_ch0_valid", bus.irq_valid, 1);
        check("t3_ch0_id", bus.irq_id, 0);
        serve();

        // Timeout after 4 unacknowledged cycles, then re-presentation.
        bus.req = 9'h004;
        tick();
        bus.req = '0;
        tick();
        check("t4_valid", bus.irq_valid, 1);
        check("t4_id2", bus.irq_id, 2);
        tick();
        tick();
        tick();
        check("t4_valid_c4", bus.irq_valid, 1);
        check("t4_terr_c4", bus.timeout_err, 0);
        tick();
        check("t4_drop", bus.irq_valid, 0);
        check("t4_terr", bus.timeout_err, 1);
        check("t4_pend_kept", bus.pending, 9'h004);
        tick();
        check("t4_terr_pulse", bus.timeout_err, 0);
        check("t4_re_valid", bus.irq_valid, 1);
        check("t4_re_id", bus.irq_id, 2);
        tick();
        tick();
        tick();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("t4_ack_last_busy", bus.busy, 1);
        check("t4_ack_last_terr", bus.timeout_err, 0);
        tick();
        check("t4_ack_last_terr2", bus.timeout_err, 0);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        check("t4_pend_empty", bus.pending, 0);

        // Request held through ack re-pends; reset during SERVICE clears everything.
        bus.req = 9'h020;
        tick();
        tick();
        check("t5_id5", bus.irq_id, 5);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("t5_busy", bus.busy, 1);
        check("t5_set_wins", bus.pending, 9'h020);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.req = '0;
        check("t5_rst_valid", bus.irq_valid, 0);
        check("t5_rst_id", bus.irq_id, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_pend", bus.pending, 0);
        check("t5_rst_terr", bus.timeout_err, 0);
        bus.irq_ack = 1'b1;
        bus.eoi     = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.eoi     = 1'b0;
        check("t5_idle_ignore_busy", bus.busy, 0);
        check("t5_idle_ignore_valid", bus.irq_valid, 0);

        // All channels held: rotation gives 0..8,0; fixed priority always 0.
        bus.req = 9'h1FF;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
`ifdef IRQ_ROTATE_PRIO_EN
            exp_id = 4'(k % NCH);
`else
            exp_id = 4'd0;
`endif
            check($sformatf("t6_valid_%0d", k), bus.irq_valid, 1);
            check($sformatf("t6_id_%0d", k), bus.irq_id, exp_id);
            serve();
            tick();
        end
        bus.req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
